password_candidate_gen: RTL and testbench

Source side of the candidate stream consumed by the password comparison workers. It enumerates every fixed-length candidate password whose first character index lies in [from, to]. Candidates are emitted as packed ASCII words over a valid/ready handshake. One instance feeds one worker; the top level assigns each instance a disjoint first-character range and aborts all instances through stop once any worker reports a match.

---
 rtl/password_candidate_gen.sv | 142 ++++++++++++++
 tb/tb_password_candidate_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/password_candidate_gen.sv
// Candidate password source: enumerates every NUM_CHARS-long string over a
// 0-9a-z alphabet whose first character index lies in [from, to], streamed
// over a valid/ready handshake with the last character incrementing fastest.
module password_candidate_gen #(
    parameter int unsigned NUM_CHARS  = 4,
    parameter int unsigned ALPHA_SIZE = 36
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [5:0]             from_i,
    input  logic [5:0]             to_i,
    input  logic                   stop_i,
    output logic                   cand_valid_o,
    input  logic                   cand_ready_i,
    output logic [8*NUM_CHARS-1:0] cand_data_o,
    output logic                   cand_last_o,
    output logic [31:0]            cand_count_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned IW = (ALPHA_SIZE > 1) ? $clog2(ALPHA_SIZE) : 1;
    localparam logic [IW-1:0] MaxIdx = IW'(ALPHA_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                       state_q;
    logic [NUM_CHARS-1:0][IW-1:0] idx_q;   // [NUM_CHARS-1] is the first character
    logic [IW-1:0]                to_q;
    logic                         valid_q;
    logic                         busy_q;
    logic                         done_q;
    logic [31:0]                  count_q;

    logic [NUM_CHARS-1:0][IW-1:0] idx_inc;
    logic                         last_c;
    logic                         xfer;
    logic                         range_ok;
    logic [8*NUM_CHARS-1:0]       ascii_c;

    function automatic logic [7:0] idx_to_ascii(input logic [IW-1:0] idx);
        logic [7:0] v;
        v = 8'(idx);
        return (v < 8'd10) ? (8'h30 + v) : (8'h57 + v);
    endfunction

    assign xfer     = valid_q & cand_ready_i;
    assign range_ok = (from_i <= to_i) && (32'(to_i) < ALPHA_SIZE);

    // Odometer increment (position 0 fastest) and last-candidate detect.
    always_comb begin
        logic carry;
        idx_inc = idx_q;
        carry   = 1'b1;
        last_c  = (idx_q[NUM_CHARS-1] == to_q);
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
            if (carry) begin
                if (idx_q[i] == MaxIdx) begin
                    idx_inc[i] = '0;
                end else begin
                    idx_inc[i] = idx_q[i] + IW'(1);
                    carry      = 1'b0;
                end
            end
            if (i < int'(NUM_CHARS) - 1 && idx_q[i] != MaxIdx) begin
                last_c = 1'b0;
            end
        end
    end

    // ASCII map of the index registers; held constant while stalled.
    always_comb begin
        ascii_c = '0;
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
            ascii_c[8*i +: 8] = idx_to_ascii(idx_q[i]);
        end
    end

    assign cand_valid_o = valid_q;
    assign cand_data_o  = valid_q ? ascii_c : '0;
    assign cand_last_o  = valid_q & last_c;
    assign cand_count_o = count_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    // Control FSM with registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            to_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // start takes priority; stop is meaningless outside RUN
                    if (start_i) begin
                        count_q <= '0;
                        if (range_ok) begin
                            idx_q              <= '0;
                            idx_q[NUM_CHARS-1] <= IW'(from_i);
                            to_q               <= IW'(to_i);
                            state_q            <= StRun;
                            valid_q            <= 1'b1;
                            busy_q             <= 1'b1;
                            done_q             <= 1'b0;
                        end else begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        count_q <= count_q + 32'd1;
                        if (!last_c) begin
                            idx_q <= idx_inc;
                        end
                    end
                    if (stop_i || (xfer && last_c)) begin
                        state_q <= StDone;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_password_candidate_gen.sv
// Directed testbench for password_candidate_gen (NUM_CHARS=4, ALPHA_SIZE=36).
module tb_password_candidate_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  from_v;
    logic [5:0]  to_v;
    logic        stop;
    logic        cand_valid;
    logic        cand_ready;
    logic [31:0] cand_data;
    logic        cand_last;
    logic [31:0] cand_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    password_candidate_gen #(
        .NUM_CHARS (4),
        .ALPHA_SIZE(36)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .from_i      (from_v),
        .to_i        (to_v),
        .stop_i      (stop),
        .cand_valid_o(cand_valid),
        .cand_ready_i(cand_ready),
        .cand_data_o (cand_data),
        .cand_last_o (cand_last),
        .cand_count_o(cand_count),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sym(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(87 + d);
    endfunction

    // Expected n-th candidate of a run starting at first index 'first'.
    function automatic logic [31:0] model(input int n, input int first);
        return {sym(first + n / 46656), sym((n / 1296) % 36), sym((n / 36) % 36), sym(n % 36)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; cand_ready = 1'b0; from_v = '0; to_v = '0;
        step(); step();
        checks++;
        if ({cand_valid, cand_last, busy, done} !== 4'b0 || cand_data !== 32'h0 ||
            cand_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b data=%h cnt=%0d, want all 0",
                     cand_valid, cand_last, busy, done, cand_data, cand_count);
        end
        rst = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (done !== 1'b0 || cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_idle: got done=%b valid=%b, want 0 0", done, cand_valid);
        end
    endtask

    task automatic test_full_run();
        int bad_data = 0;
        int bad_last = 0;
        from_v = 6'd0; to_v = 6'd0; cand_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (cand_valid !== 1'b1 || cand_data !== 32'h30303030) begin
            errors++;
            $display("FAIL first_cand: got v=%b data=%h, want 1 30303030", cand_valid, cand_data);
        end
        for (int k = 0; k < 46656; k++) begin
            if (cand_valid !== 1'b1 || cand_data !== model(k, 0)) bad_data++;
            if (k < 46655 && cand_last !== 1'b0) bad_last++;
            if (k == 359) begin
                checks++;
                if (cand_data !== 32'h3030397A) begin
                    errors++;
                    $display("FAIL pre_carry: got %h want 3030397a", cand_data);
                end
            end
            if (k == 360) begin
                checks++;
                if (cand_data !== 32'h30306130) begin
                    errors++;
                    $display("FAIL post_carry: got %h want 30306130", cand_data);
                end
            end
            if (k == 46655) begin
                checks++;
                if (cand_data !== 32'h307A7A7A || cand_last !== 1'b1) begin
                    errors++;
                    $display("FAIL last_cand: got data=%h last=%b, want 307a7a7a 1",
                             cand_data, cand_last);
                end
            end
            step();
        end
        checks++;
        if (bad_data != 0 || bad_last != 0) begin
            errors++;
            $display("FAIL stream: got %0d data and %0d early-last errors, want 0 0",
                     bad_data, bad_last);
        end
        checks++;
        if (cand_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || cand_count !== 32'd46656) begin
            errors++;
            $display("FAIL full_end: got v=%b d=%b b=%b cnt=%0d, want 0 1 0 46656",
                     cand_valid, done, busy, cand_count);
        end
        step();
        checks++;
        if (cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_last: got valid=%b want 0", cand_valid);
        end
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        from_v = 6'd0; to_v = 6'd0; cand_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        cand_ready = 1'b0;
        checks++;
        if (cand_data !== 32'h30303035) begin
            errors++;
            $display("FAIL bp_before: got %h want 30303035", cand_data);
        end
        repeat (3) begin
            step();
            if (cand_valid !== 1'b1 || cand_data !== 32'h30303035) held_bad++;
        end
        checks++;
        if (held_bad != 0 || cand_count !== 32'd5) begin
            errors++;
            $display("FAIL bp_hold: got %0d bad cycles cnt=%0d, want 0 5", held_bad, cand_count);
        end
        cand_ready = 1'b1;
        step();
        checks++;
        if (cand_data !== 32'h30303036 || cand_count !== 32'd6) begin
            errors++;
            $display("FAIL bp_release: got data=%h cnt=%0d, want 30303036 6", cand_data, cand_count);
        end
        // stop without a transfer: count unchanged
        cand_ready = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (cand_valid !== 1'b0 || done !== 1'b1 || cand_count !== 32'd6) begin
            errors++;
            $display("FAIL bp_stop: got v=%b d=%b cnt=%0d, want 0 1 6", cand_valid, done, cand_count);
        end
    endtask

    task automatic test_stop();
        from_v = 6'd4; to_v = 6'd7; cand_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || cand_count !== 32'd0) begin
            errors++;
            $display("FAIL restart: got d=%b b=%b cnt=%0d, want 0 1 0", done, busy, cand_count);
        end
        repeat (100) step();
        checks++;
        if (cand_count !== 32'd100 || cand_data !== 32'h34303273) begin
            errors++;
            $display("FAIL stop_pre: got cnt=%0d data=%h, want 100 34303273", cand_count, cand_data);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (cand_count !== 32'd101 || cand_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_post: got cnt=%0d v=%b d=%b b=%b, want 101 0 1 0",
                     cand_count, cand_valid, done, busy);
        end
    endtask

    task automatic test_invalid();
        int seen = 0;
        from_v = 6'd5; to_v = 6'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) begin
            if (cand_valid !== 1'b0) seen++;
            step();
        end
        checks++;
        if (done !== 1'b1 || seen != 0 || cand_count !== 32'd0) begin
            errors++;
            $display("FAIL inv_from_gt_to: got d=%b valid_cycles=%0d cnt=%0d, want 1 0 0",
                     done, seen, cand_count);
        end
        // short legal run so the next invalid start has a count to clear
        from_v = 6'd35; to_v = 6'd35; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (cand_count !== 32'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL short_run: got cnt=%0d d=%b, want 3 1", cand_count, done);
        end
        from_v = 6'd0; to_v = 6'd36; start = 1'b1;
        step();
        start = 1'b0;
        seen = 0;
        repeat (3) begin
            if (cand_valid !== 1'b0 || busy !== 1'b0) seen++;
            step();
        end
        checks++;
        if (done !== 1'b1 || seen != 0 || cand_count !== 32'd0) begin
            errors++;
            $display("FAIL inv_to_36: got d=%b valid_cycles=%0d cnt=%0d, want 1 0 0",
                     done, seen, cand_count);
        end
    endtask

    task automatic test_reset_mid_run();
        from_v = 6'd0; to_v = 6'd1; cand_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({cand_valid, cand_last, busy, done} !== 4'b0 || cand_data !== 32'h0 ||
            cand_count !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b l=%b b=%b d=%b data=%h cnt=%0d, want all 0",
                     cand_valid, cand_last, busy, done, cand_data, cand_count);
        end
        step();
        checks++;
        if (cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got valid=%b want 0", cand_valid);
        end
        // start and stop together: start wins
        from_v = 6'd35; to_v = 6'd35; start = 1'b1; stop = 1'b1; cand_ready = 1'b0;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (cand_valid !== 1'b1 || cand_data !== 32'h7A303030) begin
            errors++;
            $display("FAIL start_35: got v=%b data=%h, want 1 7a303030", cand_valid, cand_data);
        end
        // start during RUN is ignored
        from_v = 6'd0; to_v = 6'd0; start = 1'b1; cand_ready = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (cand_data !== 32'h7A303031 || cand_count !== 32'd1) begin
            errors++;
            $display("FAIL start_in_run: got data=%h cnt=%0d, want 7a303031 1",
                     cand_data, cand_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_stop();
        test_invalid();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
